jtag_hex_cmd: RTL
=================

Name: jtag_hex_cmd

Overview:
- Receive-side stage directly downstream of the JTAG USER-chain byte deserialiser.
- Consumes its one-cycle byte strobes, which are ASCII from the host.
- Parses hex digits and single-letter command characters into command words: a 2-bit command plus a DW-bit value.
- Hands each word to the bus-master logic over a strobe/busy handshake.
- Malformed lines are discarded up to the next newline, and dropped words are counted.

Parameters:
- DW, 32, data/address width in bits; must be a multiple of 4, max 32.
- LGDROP, 8, width of the saturating dropped-command counter.

Ports:
- i_clk  in  1  system clock; same clock as the byte deserialiser.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_stb  in  1  one-cycle strobe: i_rx_data valid.
- i_rx_data  in  8  received ASCII byte.
- o_cmd_stb  out  1  command word valid; held until accepted.
- o_cmd_word  out  DW+2  {cmd[1:0], value[DW-1:0]}.
- i_cmd_busy  in  1  consumer busy; a word is accepted on a clock edge where o_cmd_stb && !i_cmd_busy.
- o_err  out  1  one-cycle pulse on a bad character or a dropped word.
- o_drop_cnt  out  LGDROP  saturating count of words dropped for overflow.

Behaviour:

Reset (asynchronous, i_rst_n low):
- o_cmd_stb=0, o_cmd_word=0, o_err=0, o_drop_cnt=0.
- Accumulator=0, nibble count=0, state=IDLE.
- Reset asserted mid-line or mid-handshake abandons everything; no output glitch beyond the clear.

Character classes (evaluated only when i_rx_stb=1):
- HEX: '0'-'9', 'a'-'f', 'A'-'F'.
- CMD: 'S' (0x53, set address) -> cmd=2'b00; 'R' (0x52, read) -> 2'b01; 'W' (0x57, write) -> 2'b10. Code 2'b11 is reserved and never emitted.
- WS: space, tab, CR, LF (0x20, 0x09, 0x0D, 0x0A).
- BAD: everything else, including lowercase s/r/w.

States:
- IDLE
  - HEX: acc <= nibble (zero-extended), cnt <= 1, -> DIGITS.
  - CMD: emit {cmd, 0}, stay IDLE. A bare 'R' reads value 0.
  - WS: ignored.
  - BAD: o_err pulse, -> SKIP.
- DIGITS
  - HEX: acc <= {acc[DW-5:0], nibble}. cnt saturates at DW/4. MSBs shift out silently, so the last DW/4 digits win.
  - CMD: emit {cmd, acc}, clear acc and cnt, -> IDLE.
  - WS: ignored; digits on either side of whitespace concatenate.
  - BAD: o_err pulse, clear acc and cnt, -> SKIP.
- SKIP
  - LF: -> IDLE.
  - Any other byte: discarded, no further o_err.

Emit / handshake:
- Latency: the command byte strobe at cycle N gives o_cmd_stb=1 with valid o_cmd_word at cycle N+1. One holding register, no FIFO.
- o_cmd_stb and o_cmd_word stay stable while i_cmd_busy=1.
- o_cmd_stb clears the cycle after acceptance unless a new emit occurs on the accepting edge. In that case the register reloads and o_cmd_stb stays high (back-to-back).
- Emit while the holding register is occupied and not being accepted that edge:
  - The new word is dropped; the held word is preserved.
  - o_err pulses; o_drop_cnt increments, saturating at 2^LGDROP-1.
  - The parser still clears acc/cnt and returns to IDLE.
- A bad character and a drop cannot coincide, since one byte is processed per strobe.
- o_err is a single-cycle registered pulse, asserted at N+1.

Decomposition:
- Package jtag_hex_pkg holds:
  - character constants (CH_S, CH_R, CH_W, CH_LF, CH_CR, CH_SP, CH_TAB);
  - command encodings CMD_SETADR=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10;
  - the state enum {IDLE, DIGITS, SKIP}.
- One natural combinational sub-module, jtag_hex_nibble: ASCII byte -> {is_hex, nibble[3:0]}. It is reused by the future transmit-side encoder tests.

Test Plan:
1. Bytes "1234abcdW" with i_cmd_busy=0 -> one o_cmd_stb pulse one cycle after 'W', word {2'b10, 32'h1234ABCD}; o_err never asserted.
2. "R" alone, then "5 6S" -> words {01, 0x00000000} then {00, 0x00000056}; the space is ignored.
3. "123456789W" (9 digits) -> {10, 0x23456789}; cnt saturated, no error.
4. "12xW\nFFR" -> o_err one pulse at 'x'; the 'W' is discarded; after LF, {01, 0x000000FF} is emitted; exactly one word total.
5. i_cmd_busy=1 held, send "1W2W" -> first word {10, 1} held stable, second dropped; o_err pulse; o_drop_cnt=1. Release busy -> word {10, 1} accepted and o_cmd_stb falls.
6. Assert i_rst_n=0 asynchronously mid-line after "AB" with o_cmd_stb=1 -> all outputs 0 immediately. After release, "CW" -> {10, 0x0000000C}; the pre-reset digits are lost.

Source files
------------

// File: rtl/jtag_hex_pkg.sv
// Shared constants, command encodings and parser state for the JTAG hex command path.
package jtag_hex_pkg;

    localparam logic [7:0] CH_S   = 8'h53;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_W   = 8'h57;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;

    localparam logic [1:0] CMD_SETADR = 2'b00;
    localparam logic [1:0] CMD_READ   = 2'b01;
    localparam logic [1:0] CMD_WRITE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        SKIP   = 2'd2
    } state_t;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_TAB) || (c == CH_CR) || (c == CH_LF);
    endfunction

    // Returns {valid, cmd[1:0]}; only uppercase letters are commands.
    function automatic logic [2:0] cmd_decode(input logic [7:0] c);
        logic [2:0] r;
        case (c)
            CH_S:    r = {1'b1, CMD_SETADR};
            CH_R:    r = {1'b1, CMD_READ};
            CH_W:    r = {1'b1, CMD_WRITE};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jtag_hex_nibble.sv
// ASCII hex character to nibble decoder; accepts 0-9, a-f, A-F.
module jtag_hex_nibble (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nibble
);

    // Letters map by low bits: 'a'/'A' have low nibble 1, plus 9 gives 10.
    always_comb begin
        o_is_hex = 1'b0;
        o_nibble = 4'h0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0];
        end else if ((i_byte >= 8'h61 && i_byte <= 8'h66) ||
                     (i_byte >= 8'h41 && i_byte <= 8'h46)) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/jtag_hex_cmd.sv
// Parses host ASCII (hex digits + S/R/W) into command words with a strobe/busy handoff.
module jtag_hex_cmd
    import jtag_hex_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned LGDROP = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_stb,
    input  logic [7:0]        i_rx_data,
    output logic              o_cmd_stb,
    output logic [DW+1:0]     o_cmd_word,
    input  logic              i_cmd_busy,
    output logic              o_err,
    output logic [LGDROP-1:0] o_drop_cnt
);

    localparam int unsigned NDIG = DW / 4;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_t              r_state, w_state_nx;
    logic [DW-1:0]       r_acc, w_acc_nx;
    logic [CW-1:0]       r_cnt, w_cnt_nx;
    logic                r_cmd_stb;
    logic [DW+1:0]       r_cmd_word;
    logic                r_err;
    logic [LGDROP-1:0]   r_drop_cnt;

    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic [2:0]          w_cmd_dec;
    logic                w_emit;
    logic [DW-1:0]       w_emit_val;
    logic                w_bad;
    logic                w_accept;
    logic                w_load;
    logic                w_drop;

    jtag_hex_nibble u_nibble (
        .i_byte   (i_rx_data),
        .o_is_hex (w_is_hex),
        .o_nibble (w_nib)
    );

    assign w_cmd_dec = cmd_decode(i_rx_data);

    // Parser next-state: one character per strobe.
    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_emit     = 1'b0;
        w_emit_val = '0;
        w_bad      = 1'b0;
        if (i_rx_stb) begin
            case (r_state)
                IDLE: begin
                    if (w_is_hex) begin
                        w_acc_nx   = DW'(w_nib);
                        w_cnt_nx   = CW'(1);
                        w_state_nx = DIGITS;
                    end else if (w_cmd_dec[2]) begin
                        w_emit = 1'b1;
                    end else if (!is_ws(i_rx_data)) begin
                        w_bad      = 1'b1;
                        w_state_nx = SKIP;
                    end
                end
                DIGITS: begin
                    if (w_is_hex) begin
                        // Oldest digits fall off the top; the last DW/4 digits win.
                        w_acc_nx = (r_acc << 4) | DW'(w_nib);
                        if (r_cnt < CW'(NDIG)) begin
                            w_cnt_nx = r_cnt + CW'(1);
                        end
                    end else if (w_cmd_dec[2]) begin
                        w_emit     = 1'b1;
                        w_emit_val = r_acc;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = IDLE;
                    end else if (!is_ws(i_rx_data)) begin
                        w_bad      = 1'b1;
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = SKIP;
                    end
                end
                SKIP: begin
                    if (i_rx_data == CH_LF) begin
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // A new word may load only if the holding register is empty or drains this edge.
    assign w_accept = r_cmd_stb & ~i_cmd_busy;
    assign w_load   = w_emit & (~r_cmd_stb | w_accept);
    assign w_drop   = w_emit & ~w_load;

    // Parser state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Holding register, error pulse and saturating drop counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_stb  <= 1'b0;
            r_cmd_word <= '0;
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_cmd_stb <= w_load | (r_cmd_stb & ~w_accept);
            if (w_load) begin
                r_cmd_word <= {w_cmd_dec[1:0], w_emit_val};
            end
            r_err <= w_bad | w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + LGDROP'(1);
            end
        end
    end

    assign o_cmd_stb  = r_cmd_stb;
    assign o_cmd_word = r_cmd_word;
    assign o_err      = r_err;
    assign o_drop_cnt = r_drop_cnt;

endmodule
